// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants plus the sequential divider's op codes and states.
// Pure declarations; no timing or flow-control behaviour of its own.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // funct3[1:0] of the M-extension divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic div_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift remainder/quotient left, trial-subtract the divisor.
// Purely combinational, zero latency; no flow control.
module div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        rem_msb_unused;

    // The remainder always stays below the divisor, so its top bit is never set on entry.
    assign rem_msb_unused = rem_i[32];

    assign shifted = {rem_i[31:0], quo_i[31]};
    assign trial   = shifted - {1'b0, dvs_i};

    assign rem_o = trial[32] ? shifted : trial;
    assign quo_o = {quo_i[30:0], ~trial[32]};

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit divider for DIV/DIVU/REM/REMU; done rises 34 cycles after accept (2 for b==0).
// No backpressure: start is only taken when idle, flush aborts, res holds until the next done.
module div_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    div_state_e  state_q;
    logic [1:0]  op_q;
    logic [5:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] res_q;
    logic        qneg_q;
    logic        rneg_q;
    logic        dz_q;
    logic        busy_q;
    logic        done_q;

    logic [32:0] rem_d;
    logic [31:0] quo_d;
    logic        sgn;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_sel;

    assign sgn     = div_is_signed(op);
    assign a_abs   = (sgn && a[31]) ? -a : a;
    assign b_abs   = (sgn && b[31]) ? -b : b;
    assign quo_fix = qneg_q ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q[31:0] : rem_q[31:0];
    assign res_sel = op_q[1] ? rem_fix : quo_fix;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            cnt_q   <= 6'd0;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            res_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the finished op and is dropped.
                    if (start && !done_q) begin
                        op_q   <= op;
                        cnt_q  <= 6'd0;
                        busy_q <= 1'b1;
                        if (b == 32'd0) begin
                            rem_q   <= {1'b0, a};
                            quo_q   <= 32'hFFFF_FFFF;
                            dvs_q   <= 32'd0;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= 33'd0;
                            quo_q   <= a_abs;
                            dvs_q   <= b_abs;
                            qneg_q  <= sgn & (a[31] ^ b[31]);
                            rneg_q  <= sgn & a[31];
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_q   <= res_sel;
                    state_q <= DONE;
                end
                DONE: begin
                    // The divide-by-zero path loads res here, one cycle ahead of done like FIX does.
                    if (dz_q) begin
                        res_q <= res_sel;
                        dz_q  <= 1'b0;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotients/remainders, latencies, flush and reset aborts.
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_checks;
    int n_fail;

    div_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op, waits (bounded) for done, checks latency and result, then pokes start
    // during the done cycle and checks that it is ignored and that done lasted one cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat,
                          input bit disturb);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b11; a = 32'h0; b = 32'h0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        for (int n = 1; n <= 60; n++) begin
            if (disturb && n == 5) begin
                start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'd3;
            end
            if (disturb && n == 9) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, res, exp_res);
        start = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_nostart"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic count_done(input int cycles, output int dn);
        dn = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
    endtask

    initial begin
        int dn;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_res",  res, 32'd0);
        reset = 1'b0;

        run_op("divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         34, 1'b0);
        run_op("remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          34, 1'b0);
        run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b0);
        run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1'b0);
        run_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 1'b0);
        run_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1'b0);
        run_op("div_m8_m3",   2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          34, 1'b0);
        run_op("rem_m8_m3",   2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  34, 1'b0);
        run_op("div_5_0",     2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,  1'b0);
        run_op("rem_5_0",     2'b10, 32'd5,          32'd0,          32'd5,          2,  1'b0);
        run_op("remu_big_0",  2'b11, 32'h8000_0000,  32'd0,          32'h8000_0000,  2,  1'b0);
        run_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 1'b0);
        run_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 1'b0);
        run_op("divu_max_1",  2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1'b0);
        run_op("remu_max_16", 2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15,         34, 1'b0);
        run_op("busy_start",  2'b01, 32'd100,        32'd7,          32'd14,         34, 1'b1);

        // Flush at cycle 10 of a DIVU 1000/3; res must keep 14 from the previous op.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_res",  res, 32'd14);
        flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_prio", {31'b0, busy}, 32'd0);
        count_done(40, dn);
        check("flush_nodone", dn, 32'd0);
        check("flush_hold", res, 32'd14);
        run_op("after_flush", 2'b01, 32'd1000, 32'd3, 32'd333, 34, 1'b0);

        // Reset at cycle 20 of a running op discards it.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_res",  res, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        count_done(50, dn);
        check("arst_nodone", dn, 32'd0);
        check("arst_idle", {31'b0, busy}, 32'd0);
        run_op("after_rst", 2'b01, 32'd1000, 32'd3, 32'd333, 34, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; accepted only when busy=0.
REQ-004 SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the M-type divide group).
REQ-005 SHALL have port a, input, 32 bits: dividend.
REQ-006 SHALL have port b, input, 32 bits: divisor.
REQ-007 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress; start is ignored while high.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when res is valid.
REQ-010 SHALL have port res, output, 32 bits: quotient or remainder per op; holds its value until the next done.

Function
REQ-011 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-012 SHALL transition IDLE->CALC on start, registering op, |a| and |b| (absolute values for signed ops, raw values for unsigned ops), the sign of the quotient (a[31]^b[31]) and the sign of the remainder (a[31]); busy goes high in the next cycle.
REQ-013 SHALL perform CALC as 32 restoring iterations, one per cycle, using a 6-bit iteration counter that counts 0..31; each iteration shifts the remainder/quotient pair left by 1, makes a 33-bit trial subtraction of the divisor, and sets the quotient bit when the result is non-negative.
REQ-014 SHALL transition CALC->FIX when the counter reaches 31.
REQ-015 In FIX, SHALL negate the quotient when the quotient sign is set, negate the remainder when the remainder sign is set (signed ops only), select the value per op into res, and transition to DONE.
REQ-016 In DONE, SHALL assert done for exactly one cycle, deassert busy, and return to IDLE; done SHALL rise 34 cycles after the accepting edge.
REQ-017 SHALL handle b==0 by going IDLE->DONE directly: quotient = 0xFFFFFFFF and remainder = original a, for both signed and unsigned ops; done SHALL rise 2 cycles after the accepting edge.
REQ-018 For DIV/REM with a=0x80000000 and b=0xFFFFFFFF, SHALL produce quotient 0x80000000 and remainder 0 through the normal path, with no trap.
REQ-019 flush SHALL return the FSM to IDLE on the next edge from any state, deassert busy, suppress done, and leave res unchanged; flush has priority over start in the same cycle.
REQ-020 A start in the same cycle as done SHALL be ignored; start is accepted only in IDLE.
REQ-021 Inputs a, b and op SHALL be sampled only at acceptance; later changes SHALL have no effect on the result.

Reset
REQ-022 On reset, state=IDLE, busy=0, done=0, res=0, and the counter and internal registers SHALL be 0, asynchronously.
REQ-023 reset asserted mid-operation SHALL discard that operation; no done SHALL follow the release of reset.

Structure
REQ-024 The op encodings and the state enum SHALL live in the shared package alu_pkg, alongside the existing ALU opcode constants.
REQ-025 The single-iteration shift/subtract SHALL be a combinational sub-module div_step (inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor; outputs: next remainder and next quotient); there are no other sub-modules.
REQ-026 Total RTL (div_seq + div_step) SHALL be roughly 150-300 lines; no clock gating; no multi-cycle paths.

Verification
REQ-027 DIVU a=100, b=7 -> done at cycle 34, res=14; then REMU with the same operands -> res=2.
REQ-028 DIV a=-7 (0xFFFFFFF9), b=2 -> res=0xFFFFFFFD (-3); REM with the same operands -> res=0xFFFFFFFF (-1).
REQ-029 DIV a=5, b=0 -> done at cycle 2, res=0xFFFFFFFF; REM a=5, b=0 -> res=5.
REQ-030 DIV a=0x80000000, b=0xFFFFFFFF -> res=0x80000000; REM with the same operands -> res=0.
REQ-031 Start DIVU 1000/3, flush asserted at cycle 10 -> busy low the next cycle, no done, res keeps its prior value; a new start then completes with res=333.
REQ-032 Assert start while busy, and change a and b mid-operation -> both are ignored and the original result is returned; reset asserted at cycle 20 -> busy=0, res=0, no done.
